// File: rtl/apb2axi_pkg.sv
// Shared types, AXI constants and response decode for the apb2axi_32_64 bridge.
package apb2axi_pkg;

  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [2:0] AXI_SIZE_32B         = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR       = 2'b01;
  localparam logic [3:0] AXI_CACHE_MODIFIABLE = 4'b0010;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } apb2axi_state_e;

  // SLVERR (2'b10) and DECERR (2'b11) are errors; OKAY and EXOKAY are not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == 2'b10) || (resp == 2'b11);
  endfunction

endpackage

// File: rtl/apb2axi_32_64_if.sv
// APB3 completer + AXI4 manager signal bundle for apb2axi_32_64.
// slave: the bridge's view; master: the APB initiator / AXI subordinate environment.
interface apb2axi_32_64_if
  import apb2axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter int unsigned APB_ADDR_WIDTH = 12
);

  // APB
  logic                      psel_i;
  logic                      penable_i;
  logic                      pwrite_i;
  logic [APB_ADDR_WIDTH-1:0] paddr_i;
  logic [APB_DATA_W-1:0]     pwdata_i;
  logic [3:0]                pstrb_i;
  logic [APB_DATA_W-1:0]     prdata_o;
  logic                      pready_o;
  logic                      pslverr_o;

  // AXI write address
  logic [AXI_ID_WIDTH-1:0]   aw_id_o;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_o;
  logic [7:0]                aw_len_o;
  logic [2:0]                aw_size_o;
  logic [1:0]                aw_burst_o;
  logic                      aw_lock_o;
  logic [3:0]                aw_cache_o;
  logic [2:0]                aw_prot_o;
  logic [3:0]                aw_qos_o;
  logic [3:0]                aw_region_o;
  logic [AXI_USER_WIDTH-1:0] aw_user_o;
  logic                      aw_valid_o;
  logic                      aw_ready_i;

  // AXI write data
  logic [AXI_DATA_W-1:0]     w_data_o;
  logic [AXI_STRB_W-1:0]     w_strb_o;
  logic                      w_last_o;
  logic [AXI_USER_WIDTH-1:0] w_user_o;
  logic                      w_valid_o;
  logic                      w_ready_i;

  // AXI write response
  logic [AXI_ID_WIDTH-1:0]   b_id_i;
  logic [1:0]                b_resp_i;
  logic [AXI_USER_WIDTH-1:0] b_user_i;
  logic                      b_valid_i;
  logic                      b_ready_o;

  // AXI read address
  logic [AXI_ID_WIDTH-1:0]   ar_id_o;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_o;
  logic [7:0]                ar_len_o;
  logic [2:0]                ar_size_o;
  logic [1:0]                ar_burst_o;
  logic                      ar_lock_o;
  logic [3:0]                ar_cache_o;
  logic [2:0]                ar_prot_o;
  logic [3:0]                ar_qos_o;
  logic [3:0]                ar_region_o;
  logic [AXI_USER_WIDTH-1:0] ar_user_o;
  logic                      ar_valid_o;
  logic                      ar_ready_i;

  // AXI read data
  logic [AXI_ID_WIDTH-1:0]   r_id_i;
  logic [AXI_DATA_W-1:0]     r_data_i;
  logic [1:0]                r_resp_i;
  logic                      r_last_i;
  logic [AXI_USER_WIDTH-1:0] r_user_i;
  logic                      r_valid_i;
  logic                      r_ready_o;

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    output prdata_o, pready_o, pslverr_o,
    output aw_id_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_lock_o,
           aw_cache_o, aw_prot_o, aw_qos_o, aw_region_o, aw_user_o, aw_valid_o,
    input  aw_ready_i,
    output w_data_o, w_strb_o, w_last_o, w_user_o, w_valid_o,
    input  w_ready_i,
    input  b_id_i, b_resp_i, b_user_i, b_valid_i,
    output b_ready_o,
    output ar_id_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_lock_o,
           ar_cache_o, ar_prot_o, ar_qos_o, ar_region_o, ar_user_o, ar_valid_o,
    input  ar_ready_i,
    input  r_id_i, r_data_i, r_resp_i, r_last_i, r_user_i, r_valid_i,
    output r_ready_o
  );

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    input  prdata_o, pready_o, pslverr_o,
    input  aw_id_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_lock_o,
           aw_cache_o, aw_prot_o, aw_qos_o, aw_region_o, aw_user_o, aw_valid_o,
    output aw_ready_i,
    input  w_data_o, w_strb_o, w_last_o, w_user_o, w_valid_o,
    output w_ready_i,
    output b_id_i, b_resp_i, b_user_i, b_valid_i,
    input  b_ready_o,
    input  ar_id_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_lock_o,
           ar_cache_o, ar_prot_o, ar_qos_o, ar_region_o, ar_user_o, ar_valid_o,
    output ar_ready_i,
    output r_id_i, r_data_i, r_resp_i, r_last_i, r_user_i, r_valid_i,
    input  r_ready_o
  );

endinterface

// File: rtl/apb2axi_32_64.sv
// APB3 completer to 64-bit AXI4 manager bridge: one single-beat AXI transaction per
// APB transfer, one outstanding at a time. All bus outputs are registered.
// Optional: define APB2AXI_PSTRB_EN to honour APB4 pstrb instead of full-word strobes.
module apb2axi_32_64
  import apb2axi_pkg::*;
#(
  parameter int unsigned               AXI_ADDR_WIDTH = 64,
  parameter int unsigned               AXI_ID_WIDTH   = 4,
  parameter int unsigned               AXI_USER_WIDTH = 1,
  parameter int unsigned               AXI_ID         = 0,
  parameter int unsigned               APB_ADDR_WIDTH = 12,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_ADDR  = '0
) (
  input logic              clk_i,
  input logic              rst_i,
  apb2axi_32_64_if.slave   bus
);

  apb2axi_state_e state_q, state_d;

  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic aw_valid_q, aw_valid_d;
  logic w_valid_q, w_valid_d;
  logic ar_valid_q, ar_valid_d;
  logic b_ready_q, b_ready_d;
  logic r_ready_q, r_ready_d;
  logic pready_q, pready_d;
  logic pslverr_q, pslverr_d;

  logic [APB_DATA_W-1:0]     prdata_q, prdata_d;
  logic [AXI_DATA_W-1:0]     w_data_q, w_data_d;
  logic [AXI_STRB_W-1:0]     w_strb_q, w_strb_d;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;

  logic [APB_ADDR_WIDTH-1:0] paddr_c;
  logic [AXI_ADDR_WIDTH-1:0] addr_c;
  logic                      lane_c;
  logic                      setup_c;
  logic [AXI_STRB_W-1:0]     wr_strb_c;
  logic                      aw_fire_c, w_fire_c, b_fire_c, ar_fire_c, r_fire_c;

  // Address translation and handshake decode
  assign paddr_c   = bus.paddr_i;
  assign addr_c    = AXI_BASE_ADDR + AXI_ADDR_WIDTH'(paddr_c);
  assign lane_c    = addr_c[2];
  assign setup_c   = bus.psel_i & ~bus.penable_i;
  assign aw_fire_c = aw_valid_q & bus.aw_ready_i;
  assign w_fire_c  = w_valid_q & bus.w_ready_i;
  assign b_fire_c  = b_ready_q & bus.b_valid_i;
  assign ar_fire_c = ar_valid_q & bus.ar_ready_i;
  assign r_fire_c  = r_ready_q & bus.r_valid_i;

  // Write strobe for the selected 32-bit lane
`ifdef APB2AXI_PSTRB_EN
  assign wr_strb_c = lane_c ? {bus.pstrb_i, 4'h0} : {4'h0, bus.pstrb_i};
`else
  assign wr_strb_c = lane_c ? 8'hF0 : 8'h0F;
  logic unused_pstrb_c;
  assign unused_pstrb_c = ^bus.pstrb_i;
`endif

  // IDs, r_last and user returns carry no information with one transaction in flight
  logic unused_resp_c;
  assign unused_resp_c = ^{bus.b_id_i, bus.b_user_i, bus.r_id_i, bus.r_last_i, bus.r_user_i};

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_addr_q  <= '0;
      ar_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      b_ready_q  <= b_ready_d;
      r_ready_q  <= r_ready_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      aw_addr_q  <= aw_addr_d;
      ar_addr_q  <= ar_addr_d;
    end
  end

  // Next-state decode; a captured transfer always runs to completion on AXI
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup_c) state_d = bus.pwrite_i ? WR_REQ : RD_REQ;
      WR_REQ:  if ((aw_done_q | aw_fire_c) & (w_done_q | w_fire_c)) state_d = WR_RESP;
      WR_RESP: if (b_fire_c) state_d = DONE;
      RD_REQ:  if (ar_fire_c) state_d = RD_RESP;
      RD_RESP: if (r_fire_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the upcoming state
  always_comb begin
    aw_done_d  = 1'b0;
    w_done_d   = 1'b0;
    pslverr_d  = pslverr_q;
    prdata_d   = prdata_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    aw_addr_d  = aw_addr_q;
    ar_addr_d  = ar_addr_q;

    if (state_q == WR_REQ) begin
      aw_done_d = aw_done_q | aw_fire_c;
      w_done_d  = w_done_q | w_fire_c;
    end

    if ((state_q == IDLE) && setup_c) begin
      pslverr_d = 1'b0;
      if (bus.pwrite_i) begin
        aw_addr_d = addr_c;
        w_data_d  = {bus.pwdata_i, bus.pwdata_i};
        w_strb_d  = wr_strb_c;
      end else begin
        ar_addr_d = addr_c;
      end
    end

    if (b_fire_c) pslverr_d = resp_is_err(bus.b_resp_i);
    if (r_fire_c) begin
      pslverr_d = resp_is_err(bus.r_resp_i);
      prdata_d  = ar_addr_q[2] ? bus.r_data_i[63:32] : bus.r_data_i[31:0];
    end

    aw_valid_d = (state_d == WR_REQ) & ~aw_done_d;
    w_valid_d  = (state_d == WR_REQ) & ~w_done_d;
    ar_valid_d = (state_d == RD_REQ);
    b_ready_d  = (state_d == WR_RESP);
    r_ready_d  = (state_d == RD_RESP);
    pready_d   = (state_d == DONE);
  end

  // Output wiring
  assign bus.prdata_o    = prdata_q;
  assign bus.pready_o    = pready_q;
  assign bus.pslverr_o   = pslverr_q;

  assign bus.aw_id_o     = AXI_ID_WIDTH'(AXI_ID);
  assign bus.aw_addr_o   = aw_addr_q;
  assign bus.aw_len_o    = 8'd0;
  assign bus.aw_size_o   = AXI_SIZE_32B;
  assign bus.aw_burst_o  = AXI_BURST_INCR;
  assign bus.aw_lock_o   = 1'b0;
  assign bus.aw_cache_o  = AXI_CACHE_MODIFIABLE;
  assign bus.aw_prot_o   = 3'b000;
  assign bus.aw_qos_o    = 4'h0;
  assign bus.aw_region_o = 4'h0;
  assign bus.aw_user_o   = AXI_USER_WIDTH'(0);
  assign bus.aw_valid_o  = aw_valid_q;

  assign bus.w_data_o    = w_data_q;
  assign bus.w_strb_o    = w_strb_q;
  assign bus.w_last_o    = 1'b1;
  assign bus.w_user_o    = AXI_USER_WIDTH'(0);
  assign bus.w_valid_o   = w_valid_q;

  assign bus.b_ready_o   = b_ready_q;

  assign bus.ar_id_o     = AXI_ID_WIDTH'(AXI_ID);
  assign bus.ar_addr_o   = ar_addr_q;
  assign bus.ar_len_o    = 8'd0;
  assign bus.ar_size_o   = AXI_SIZE_32B;
  assign bus.ar_burst_o  = AXI_BURST_INCR;
  assign bus.ar_lock_o   = 1'b0;
  assign bus.ar_cache_o  = AXI_CACHE_MODIFIABLE;
  assign bus.ar_prot_o   = 3'b000;
  assign bus.ar_qos_o    = 4'h0;
  assign bus.ar_region_o = 4'h0;
  assign bus.ar_user_o   = AXI_USER_WIDTH'(0);
  assign bus.ar_valid_o  = ar_valid_q;

  assign bus.r_ready_o   = r_ready_q;

endmodule

// File: tb/tb_apb2axi_32_64.sv
// Directed, table-driven bench for apb2axi_32_64 with a cycle-stepped AXI responder.
module tb_apb2axi_32_64;

  localparam int unsigned AW  = 64;
  localparam int unsigned IDW = 4;
  localparam int unsigned UW  = 1;
  localparam int unsigned PAW = 12;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int unsigned NV = 12;

  // {len,size,burst,lock,cache,prot,qos,region,user,id} with AXI_ID = 5
  localparam logic [33:0] EXP_CONST = {8'h00, 3'd2, 2'b01, 1'b0, 4'b0010, 3'b000,
                                       4'h0, 4'h0, 1'b0, 4'h5};
`ifdef APB2AXI_PSTRB_EN
  localparam logic [7:0] STRB_V10 = 8'h05;
`else
  localparam logic [7:0] STRB_V10 = 8'h0F;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb2axi_32_64_if #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IDW), .AXI_USER_WIDTH(UW),
                     .APB_ADDR_WIDTH(PAW)) bus ();

  apb2axi_32_64 #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IDW), .AXI_USER_WIDTH(UW),
                  .AXI_ID(5), .APB_ADDR_WIDTH(PAW), .AXI_BASE_ADDR(BASE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    bit          wr;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [63:0] rdata;
    logic [1:0]  resp;
    int          da;      // first cycle aw_ready / ar_ready is high
    int          dw;      // first cycle w_ready is high
    logic [63:0] exp_addr;
    logic [7:0]  exp_strb;
    logic [31:0] exp_prdata;
    bit          exp_err;
    int          exp_done; // cycle (setup = 0) in which pready is high
  } vec_t;

  vec_t vecs [NV];
  int total;
  int bad;

  function automatic vec_t mk(bit wr, logic [11:0] pa, logic [31:0] wd, logic [3:0] ps,
                              logic [63:0] rd, logic [1:0] rs, int da, int dw,
                              logic [63:0] ea, logic [7:0] es, logic [31:0] ep,
                              bit ee, int ed);
    vec_t v;
    v.wr = wr; v.paddr = pa; v.pwdata = wd; v.pstrb = ps; v.rdata = rd; v.resp = rs;
    v.da = da; v.dw = dw; v.exp_addr = ea; v.exp_strb = es; v.exp_prdata = ep;
    v.exp_err = ee; v.exp_done = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    bus.paddr_i = '0; bus.pwdata_i = '0; bus.pstrb_i = '0;
    bus.aw_ready_i = 1'b0; bus.w_ready_i = 1'b0; bus.ar_ready_i = 1'b0;
    bus.b_id_i = '0; bus.b_resp_i = '0; bus.b_user_i = '0; bus.b_valid_i = 1'b0;
    bus.r_id_i = '0; bus.r_data_i = '0; bus.r_resp_i = '0; bus.r_last_i = 1'b0;
    bus.r_user_i = '0; bus.r_valid_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ctl"}, 64'({bus.aw_valid_o, bus.w_valid_o, bus.ar_valid_o, bus.b_ready_o,
                           bus.r_ready_o, bus.pready_o, bus.pslverr_o}), 64'd0);
    chk({tag, " prdata"}, 64'(bus.prdata_o), 64'd0);
    chk({tag, " wdata"}, bus.w_data_o, 64'd0);
    chk({tag, " wstrb"}, 64'(bus.w_strb_o), 64'd0);
    chk({tag, " awaddr"}, bus.aw_addr_o, 64'd0);
    chk({tag, " araddr"}, bus.ar_addr_o, 64'd0);
  endtask

  // One APB transfer; AXI side answered per the vector's ready schedule.
  task automatic run_vec(input vec_t v, input int idx);
    int done_k, aw_hs, w_hs, ar_hs, viol;
    bit aw_done, w_done, ar_done, rsp_done;
    logic [63:0] cap_addr, cap_wdata;
    logic [7:0]  cap_strb;
    logic [33:0] cap_const;
    logic [1:0]  cap_wlu;
    logic [31:0] cap_prdata;
    logic        cap_err;
    string tag;
    done_k = -1; aw_hs = 0; w_hs = 0; ar_hs = 0; viol = 0;
    aw_done = 0; w_done = 0; ar_done = 0; rsp_done = 0;
    cap_addr = '0; cap_wdata = '0; cap_strb = '0; cap_const = '0; cap_wlu = '0;
    cap_prdata = '0; cap_err = 1'b0;
    tag = $sformatf("v%0d", idx);

    @(negedge clk);
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = v.wr;
    bus.paddr_i = v.paddr; bus.pwdata_i = v.pwdata; bus.pstrb_i = v.pstrb;
    chk({tag, " setup pready"}, 64'(bus.pready_o), 64'd0);

    for (int k = 1; k <= 40 && done_k < 0; k++) begin
      @(negedge clk);
      bus.penable_i = 1'b1;
      if (bus.pready_o) begin
        done_k = k; cap_prdata = bus.prdata_o; cap_err = bus.pslverr_o;
      end else begin
        bus.aw_ready_i = (k >= v.da);
        bus.ar_ready_i = (k >= v.da);
        bus.w_ready_i  = (k >= v.dw);
        bus.b_valid_i  = v.wr & aw_done & w_done & ~rsp_done;
        bus.b_resp_i   = v.resp;
        bus.r_valid_i  = ~v.wr & ar_done & ~rsp_done;
        bus.r_resp_i   = v.resp;
        bus.r_data_i   = v.rdata;
        if (v.wr) begin
          if (bus.aw_valid_o != !aw_done) viol++;
          if (bus.w_valid_o != !w_done) viol++;
          if (bus.ar_valid_o) viol++;
        end else begin
          if (bus.ar_valid_o != !ar_done) viol++;
          if (bus.aw_valid_o || bus.w_valid_o) viol++;
        end
        if (bus.aw_valid_o && bus.aw_ready_i) begin
          aw_hs++; aw_done = 1; cap_addr = bus.aw_addr_o;
          cap_const = {bus.aw_len_o, bus.aw_size_o, bus.aw_burst_o, bus.aw_lock_o,
                       bus.aw_cache_o, bus.aw_prot_o, bus.aw_qos_o, bus.aw_region_o,
                       bus.aw_user_o, bus.aw_id_o};
        end
        if (bus.w_valid_o && bus.w_ready_i) begin
          w_hs++; w_done = 1; cap_wdata = bus.w_data_o; cap_strb = bus.w_strb_o;
          cap_wlu = {bus.w_last_o, bus.w_user_o};
        end
        if (bus.ar_valid_o && bus.ar_ready_i) begin
          ar_hs++; ar_done = 1; cap_addr = bus.ar_addr_o;
          cap_const = {bus.ar_len_o, bus.ar_size_o, bus.ar_burst_o, bus.ar_lock_o,
                       bus.ar_cache_o, bus.ar_prot_o, bus.ar_qos_o, bus.ar_region_o,
                       bus.ar_user_o, bus.ar_id_o};
        end
        if ((bus.b_valid_i && bus.b_ready_o) || (bus.r_valid_i && bus.r_ready_o))
          rsp_done = 1;
      end
    end
    idle_inputs();

    chk({tag, " pready cycle"}, 64'(done_k), 64'(v.exp_done));
    chk({tag, " pslverr"}, 64'(cap_err), 64'(v.exp_err));
    chk({tag, " addr"}, cap_addr, v.exp_addr);
    chk({tag, " const fields"}, 64'(cap_const), 64'(EXP_CONST));
    chk({tag, " valid hold"}, 64'(viol), 64'd0);
    if (v.wr) begin
      chk({tag, " aw count"}, 64'(aw_hs), 64'd1);
      chk({tag, " w count"}, 64'(w_hs), 64'd1);
      chk({tag, " wdata"}, cap_wdata, {v.pwdata, v.pwdata});
      chk({tag, " wstrb"}, 64'(cap_strb), 64'(v.exp_strb));
      chk({tag, " wlast/wuser"}, 64'(cap_wlu), 64'd2);
    end else begin
      chk({tag, " ar count"}, 64'(ar_hs), 64'd1);
      chk({tag, " prdata"}, 64'(cap_prdata), 64'(v.exp_prdata));
    end

    @(negedge clk);
    chk({tag, " pready single"}, 64'(bus.pready_o), 64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = mk(1, 12'h104, 32'hDEADBEEF, 4'hF, 64'h0, 2'b00, 1, 1,
                  64'h8000_0104, 8'hF0, 32'h0, 0, 3);
    vecs[1]  = mk(0, 12'h008, 32'h0, 4'h0, 64'h1111_2222_3333_4444, 2'b00, 1, 1,
                  64'h8000_0008, 8'h00, 32'h3333_4444, 0, 3);
    vecs[2]  = mk(0, 12'h00C, 32'h0, 4'h0, 64'h1111_2222_3333_4444, 2'b00, 1, 1,
                  64'h8000_000C, 8'h00, 32'h1111_2222, 0, 3);
    vecs[3]  = mk(1, 12'h010, 32'h1234_5678, 4'hF, 64'h0, 2'b00, 6, 1,
                  64'h8000_0010, 8'h0F, 32'h0, 0, 8);
    vecs[4]  = mk(1, 12'h01C, 32'hA5A5_0F0F, 4'hF, 64'h0, 2'b00, 4, 4,
                  64'h8000_001C, 8'hF0, 32'h0, 0, 6);
    vecs[5]  = mk(1, 12'h020, 32'h0000_0001, 4'hF, 64'h0, 2'b10, 1, 1,
                  64'h8000_0020, 8'h0F, 32'h0, 1, 3);
    vecs[6]  = mk(0, 12'h024, 32'h0, 4'h0, 64'hCAFE_F00D_0BAD_C0DE, 2'b11, 1, 1,
                  64'h8000_0024, 8'h00, 32'hCAFE_F00D, 1, 3);
    vecs[7]  = mk(0, 12'h000, 32'h0, 4'h0, 64'hCAFE_F00D_0BAD_C0DE, 2'b01, 1, 1,
                  64'h8000_0000, 8'h00, 32'h0BAD_C0DE, 0, 3);
    vecs[8]  = mk(0, 12'h003, 32'h0, 4'h0, 64'h5555_6666_7777_8888, 2'b00, 3, 1,
                  64'h8000_0003, 8'h00, 32'h7777_8888, 0, 5);
    vecs[9]  = mk(1, 12'hFFC, 32'h0BEE_F00D, 4'hF, 64'h0, 2'b00, 1, 3,
                  64'h8000_0FFC, 8'hF0, 32'h0, 0, 5);
    vecs[10] = mk(1, 12'h000, 32'hFFFF_FFFF, 4'b0101, 64'h0, 2'b00, 1, 1,
                  64'h8000_0000, STRB_V10, 32'h0, 0, 3);
    vecs[11] = mk(1, 12'h008, 32'h7654_3210, 4'hF, 64'h0, 2'b01, 1, 1,
                  64'h8000_0008, 8'h0F, 32'h0, 0, 3);

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < int'(NV); i++) run_vec(vecs[i], i);

    // Reset while waiting for R after AR was accepted
    @(negedge clk);
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0; bus.paddr_i = 12'h008;
    @(negedge clk);
    bus.penable_i = 1'b1; bus.ar_ready_i = 1'b1;
    @(negedge clk);
    bus.ar_ready_i = 1'b0;
    chk("midrst r_ready", 64'(bus.r_ready_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    idle_inputs();
    rst = 1'b0;
    run_vec(vecs[0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb2axi_32_64.md
# apb2axi_32_64

Bridges a 32-bit APB3 completer port onto a 64-bit AXI4 manager port. It issues exactly one single-beat AXI transaction per APB transfer, so APB-attached initiators (debug or boot controllers) can reach memory behind the AXI crossbar. It is the reverse of the AXI-to-APB bridge and sits between an APB initiator and an AXI crossbar slave port. Only one transaction is ever outstanding.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 64, AXI address width
- AXI_ID_WIDTH, 4, AXI ID width
- AXI_USER_WIDTH, 1, AXI user width
- AXI_ID, 0, constant ID driven on AW/AR
- APB_ADDR_WIDTH, 12, PADDR width
- AXI_BASE_ADDR, 0, added to the zero-extended PADDR to form the AXI address

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- psel_i, penable_i, pwrite_i  in  1 each  APB control
- paddr_i  in  APB_ADDR_WIDTH  APB address
- pwdata_i  in  32  write data
- pstrb_i  in  4  byte strobes (used only with APB2AXI_PSTRB_EN)
- prdata_o  out  32  read data
- pready_o, pslverr_o  out  1 each  APB completion and error
- aw_* out: id/addr/len(8)/size(3)/burst(2)/lock/cache(4)/prot(3)/qos(4)/region(4)/user/valid; aw_ready_i  in
- w_data_o  out  64; w_strb_o  out  8; w_last_o, w_user_o, w_valid_o  out; w_ready_i  in
- b_id_i, b_resp_i(2), b_user_i, b_valid_i  in; b_ready_o  out
- ar_* out: same field set as aw_*; ar_ready_i  in
- r_id_i, r_data_i(64), r_resp_i(2), r_last_i, r_user_i, r_valid_i  in; r_ready_o  out

## Operation
- Constant fields: len=0, size=3'd2, burst=INCR, lock=0, cache=4'b0010, prot=3'b000, qos=0, region=0, user=0, w_last=1.
- Address: AXI_BASE_ADDR + {zeros, paddr}, computed at AXI_ADDR_WIDTH and wrapping modulo 2^AXI_ADDR_WIDTH. PADDR[1:0] is passed through unchanged.
- Write lane: lane = addr[2]. w_data = {pwdata, pwdata}. w_strb = 8'h0F if lane is 0, else 8'hF0.
- Read lane: prdata = lane ? r_data[63:32] : r_data[31:0].
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
  - IDLE: psel & !penable captures address, data and direction. Moves to WR_REQ or RD_REQ.
  - WR_REQ: aw_valid and w_valid are asserted together. Each drops independently after its own handshake. The state moves to WR_RESP in the cycle after both handshakes have completed; the two handshakes may occur in the same cycle or in either order.
  - WR_RESP: b_ready=1. A b handshake latches pslverr = b_resp[1] and moves to DONE.
  - RD_REQ: ar_valid=1. An ar handshake moves to RD_RESP.
  - RD_RESP: r_ready=1. An r handshake latches the read data lane and pslverr = r_resp[1], then moves to DONE.
  - DONE: pready=1 for exactly one cycle, then IDLE.
- OKAY and EXOKAY complete without error. SLVERR and DECERR set pslverr.
- b_id, r_id and r_last are ignored, because only one transaction is outstanding.
- Once captured, a transfer always completes on AXI, even if PSEL drops; this is an APB protocol violation and is tolerated.

## Timing
- Reset values of all outputs: valids/readies 0, pready 0, pslverr 0, prdata 0, w_data/w_strb 0, addresses 0. FSM returns to IDLE.
- Reset mid-transaction aborts immediately and drops all valids. The system resets both ends together.
- All AXI outputs are registered. No combinational path exists from any *_ready_i / *_valid_i to any output.
- Zero-wait AXI latency, with setup at cycle T0:
  - write: AW and W valid in T1, B handshake in T2, pready in T3.
  - read: AR in T1, R in T2, pready in T3.
- The APB access phase is therefore at least 3 cycles. pready is never asserted in the setup phase.
- prdata and pslverr are valid only in the pready cycle. prdata holds its value afterwards.

## Configuration
- APB2AXI_PSTRB_EN defined: APB4 strobes are honoured. w_strb = lane ? {pstrb, 4'h0} : {4'h0, pstrb}. A write with pstrb=0 still issues an AXI write with a zero strobe.
- APB2AXI_PSTRB_EN undefined: pstrb_i is ignored and full-word strobes are used.

## Structure
- Package apb2axi_pkg holds:
  - the state enum type apb2axi_state_e;
  - the constants AXI_SIZE_32B, AXI_BURST_INCR and AXI_CACHE_MODIFIABLE;
  - the resp-is-error function.
- No sub-module is needed; the block is a single FSM and datapath.

## Test plan
- Write paddr=12'h104, pwdata=32'hDEADBEEF, base 0x8000_0000, zero-wait AXI:
  - aw_addr=0x8000_0104, w_data={2{DEADBEEF}}, w_strb=8'hF0;
  - pready rises at T3, pslverr=0.
- Read paddr=12'h008 with r_data=64'h1111_2222_3333_4444: prdata=32'h3333_4444. Read paddr=12'h00C with the same r_data: prdata=32'h1111_2222.
- Handshake ordering:
  - w_ready 5 cycles before aw_ready: single AW and single W, each held until its handshake;
  - aw_ready and w_ready in the same cycle: AW and W both complete in that cycle.
- b_resp=2'b10: pslverr=1 in the pready cycle. r_resp=2'b11: pslverr=1. r_resp=2'b01: pslverr=0.
- Reset asserted in RD_RESP with ar accepted: all outputs 0 in the following cycle. After release, a fresh write completes normally.
- With APB2AXI_PSTRB_EN, pstrb=4'b0101 at paddr=12'h000: w_strb=8'h05.
